sysid_check_ctrl: RTL and testbench

//   Avalon-MM master that sequences reads of the system-ID slave: word 0 (ID) and word 1 (build timestamp).

---
 rtl/sysid_check_ctrl_pkg.sv | 23 ++
 rtl/sysid_check_ctrl_wait_timer.sv | 32 +++
 rtl/sysid_check_ctrl.sv | 149 ++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_ctrl_pkg.sv
// Shared definitions for the system-ID check controller.
//   state_t        : 3-bit FSM state encodings
//   SYSID_ADDR_*   : word addresses inside the system-ID slave
//   SYSID_EXP_*    : default expected ID and build timestamp; the same
//                    values appear in the software headers
package sysid_check_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_GAP   = 3'd3,
        ST_CMP   = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID = 32'd123456789;
    localparam logic [31:0] SYSID_EXP_TS = 32'd1375177753;

endpackage

// File: rtl/sysid_check_ctrl_wait_timer.sv
// sysid_wait_timer: 8-bit saturating wait-cycle counter.
//   clock, reset_n : clock and synchronous active-low reset
//   clr            : return the count to zero (has priority over inc)
//   inc            : count one more stalled cycle
//   limit          : number of stalled cycles tolerated (1..255)
//   expired        : high in the cycle whose increment reaches limit, so
//                    the owner can leave on exactly the limit-th stall
module sysid_wait_timer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // Compared in 9 bits so a saturated count cannot wrap past the limit.
    assign expired = inc && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: Avalon-MM master that reads the system-ID slave
// (word 0 = ID, word 1 = build timestamp), compares both words with the
// expected values and reports the result to the boot/health logic.
//
// Ports
//   clock, reset_n     : clock, synchronous active-low reset
//   start              : one-cycle request, dropped while busy
//   avm_address        : 0 = ID word, 1 = timestamp word
//   avm_read           : read strobe
//   avm_readdata       : read data from the slave
//   avm_waitrequest    : slave stall
//   busy               : a check is in progress
//   done               : one-cycle pulse at the end of every check
//   id_ok, ts_ok       : captured word equals the expected value
//   timeout_err        : last check aborted after all retries timed out
//   id_value, ts_value : last captured words
//   dbg_state          : current FSM state
//
// Handshake: a read is a transfer in every cycle where avm_read=1 and
// avm_waitrequest=0; avm_readdata is taken in that same cycle. While
// avm_waitrequest=1 the master holds avm_read and avm_address unchanged
// until acceptance or until the wait limit drops the read for a one-cycle
// gap before the retry.
module sysid_check_ctrl
    import sysid_check_ctrl_pkg::*;
#(
    parameter logic [31:0] EXP_ID      = SYSID_EXP_ID,
    parameter logic [31:0] EXP_TS      = SYSID_EXP_TS,
    parameter bit          AUTO_START  = 1'b1,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          MAX_RETRY   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  dbg_state
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    localparam logic [7:0] WAIT_LIMIT  = 8'(TIMEOUT_CYC);

    state_t     state;
    logic [1:0] retry;
    logic       started;   // low only until the first cycle after reset release
    logic       in_read;
    logic       wait_expired;

    assign in_read   = (state == ST_RD_ID) || (state == ST_RD_TS);
    assign dbg_state = state;

    sysid_wait_timer u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (!in_read || !avm_waitrequest),
        .inc     (in_read && avm_waitrequest),
        .limit   (WAIT_LIMIT),
        .expired (wait_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            retry       <= 2'd0;
            started     <= 1'b0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            started <= 1'b1;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start || (AUTO_START && !started)) begin
                        state       <= ST_RD_ID;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        retry       <= 2'd0;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        if (state == ST_RD_ID) begin
                            id_value    <= avm_readdata;
                            avm_address <= SYSID_ADDR_TS;
                            state       <= ST_RD_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            avm_read <= 1'b0;
                            state    <= ST_CMP;
                        end
                    end else if (wait_expired) begin
                        // Address is left as is: GAP uses it to pick the phase to retry.
                        avm_read <= 1'b0;
                        if (retry < RETRY_LIMIT) begin
                            retry <= retry + 2'd1;
                            state <= ST_GAP;
                        end else begin
                            state <= ST_FAIL;
                        end
                    end
                end
                ST_GAP: begin
                    avm_read <= 1'b1;
                    state    <= (avm_address == SYSID_ADDR_TS) ? ST_RD_TS : ST_RD_ID;
                end
                ST_CMP: begin
                    id_ok <= (id_value == EXP_ID);
                    ts_ok <= (ts_value == EXP_TS);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_FAIL: begin
                    timeout_err <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: directed checks with a done-driven scoreboard.
module tb_sysid_check_ctrl;

    localparam int W = 83;  // {done cycle[15:0], id_ok, ts_ok, timeout_err, id_value, ts_value}
    localparam logic [31:0] GOOD_ID = 32'd123456789;
    localparam logic [31:0] GOOD_TS = 32'd1375177753;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;
    logic [2:0]  dbg_state;

    sysid_check_ctrl #(
        .AUTO_START  (1'b1),
        .TIMEOUT_CYC (4),
        .MAX_RETRY   (2)
    ) dut (
        .clock           (clk),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .dbg_state       (dbg_state)
    );

    // ---------------- slave model ----------------
    logic [31:0] slave_id = GOOD_ID;
    logic [31:0] slave_ts = GOOD_TS;
    int          id_stall = 0;
    int          ts_stall = 0;

    assign avm_readdata = avm_address ? slave_ts : slave_id;

    // Waitrequest for the coming edge is decided mid-cycle from the current request.
    always @(negedge clk) begin
        if (avm_read === 1'b1 && avm_address === 1'b0 && id_stall > 0) begin
            avm_waitrequest = 1'b1;
            id_stall = id_stall - 1;
        end else if (avm_read === 1'b1 && avm_address === 1'b1 && ts_stall > 0) begin
            avm_waitrequest = 1'b1;
            ts_stall = ts_stall - 1;
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic i_ok, input logic t_ok, input logic t_err,
                            input logic [31:0] i_val, input logic [31:0] t_val);
        exp_q.push_back({16'(c), i_ok, t_ok, t_err, i_val, t_val});
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (done === 1'b1) begin
            act = {cyc[15:0], id_ok, ts_ok, timeout_err, id_value, ts_value};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done at cycle %0d: got resp %0h expected none", cyc, act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL resp: got cyc=%0d ok=%b%b to=%b id=%0h ts=%0h expected cyc=%0d ok=%b%b to=%b id=%0h ts=%0h",
                             act[82:67], act[66], act[65], act[64], act[63:32], act[31:0],
                             exp[82:67], exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        logic [4:0]  bz_tr;
        logic [4:0]  rd_tr;
        logic [5:0]  rd5_tr;
        logic [4:0]  ad5_tr;
        logic [15:0] rd4_tr;
        logic [15:0] ad4_tr;

        // Reset state.
        goto(3);
        check("reset_ctrl", {57'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}, 64'd0);
        check("reset_values", {id_value, ts_value}, 64'd0);
        check("reset_state", {61'd0, dbg_state}, 64'd0);

        // Auto start: reset released in cycle 5 -> read of word 0 in 6, done in 9.
        goto(5);
        reset_n = 1'b1;
        push_exp(9, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
        goto(6);
        check("auto_read", {62'd0, avm_read, avm_address}, 64'b10);

        // Good slave, start in cycle 10 -> busy 11..13, reads 11..12, done 14.
        push_exp(14, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
        for (int c = 10; c <= 14; c++) begin
            goto(c);
            bz_tr = {bz_tr[3:0], busy};
            rd_tr = {rd_tr[3:0], avm_read};
            start = (c == 10);
        end
        check("busy_window", {59'd0, bz_tr}, 64'b01110);
        check("read_window", {59'd0, rd_tr}, 64'b01100);

        // Timestamp word returns zero.
        goto(18);
        slave_ts = 32'h0;
        goto(20);
        start = 1'b1;
        push_exp(24, 1'b1, 1'b0, 1'b0, GOOD_ID, 32'h0);
        goto(21);
        start = 1'b0;
        goto(25);
        slave_ts = GOOD_TS;

        // Three stalls on word 0 (one below the limit) -> done at start+7.
        goto(30);
        id_stall = 3;
        start = 1'b1;
        push_exp(37, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
        for (int c = 31; c <= 36; c++) begin
            goto(c);
            start = 1'b0;
            rd5_tr = {rd5_tr[4:0], avm_read};
            if (c <= 35) ad5_tr = {ad5_tr[3:0], avm_address};
        end
        check("stall_read", {58'd0, rd5_tr}, 64'b111110);
        check("stall_addr", {59'd0, ad5_tr}, 64'b00001);

        // Word 1 stuck: three bursts of 4 reads with 1-cycle gaps, then timeout.
        // A start pulse in the middle must be dropped.
        goto(40);
        ts_stall = 1000;
        start = 1'b1;
        push_exp(57, 1'b0, 1'b0, 1'b1, GOOD_ID, GOOD_TS);
        for (int c = 41; c <= 56; c++) begin
            goto(c);
            start = (c == 48);
            rd4_tr = {rd4_tr[14:0], avm_read};
            ad4_tr = {ad4_tr[14:0], avm_address};
        end
        check("retry_read", {48'd0, rd4_tr}, 64'hFBDE);
        check("retry_addr", {48'd0, ad4_tr}, 64'h7FFF);
        goto(58);
        ts_stall = 0;

        // Wrong ID, then a start in the done cycle is honoured.
        goto(60);
        slave_id = 32'hDEADBEEF;
        start = 1'b1;
        push_exp(64, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, GOOD_TS);
        goto(61);
        start = 1'b0;
        goto(64);
        slave_id = GOOD_ID;
        start = 1'b1;
        push_exp(68, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
        goto(65);
        start = 1'b0;

        // Reset for one cycle while reading word 1.
        goto(80);
        start = 1'b1;
        goto(81);
        start = 1'b0;
        goto(82);
        check("pre_reset_state", {61'd0, dbg_state}, 64'd2);
        reset_n = 1'b0;
        goto(83);
        check("mid_reset_ctrl", {57'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}, 64'd0);
        check("mid_reset_values", {id_value, ts_value}, 64'd0);
        reset_n = 1'b1;
        // Release re-arms the automatic check; the start at 85 is ignored.
        push_exp(87, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
        goto(85);
        start = 1'b1;
        goto(86);
        start = 1'b0;

        goto(100);
        check("pending_expect", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
